dma_priority_arbiter: RTL and testbench
=======================================

Name: dma_priority_arbiter

Overview:
Parametrised DREQ/DACK arbiter and bus-hold handshake for the multi-channel DMA controller, generalised from the fixed 4-channel design to NUM_CH channels.
- Inputs: raw DREQ lines, mask bits and software requests.
- Arbitration: resolves fixed or rotating priority.
- Handshake: negotiates HRQ/HLDA with the CPU, then holds one DACK until timing-and-control signals end of service.
- Placement: sits between the command/mode/mask registers and the timing-and-control FSM.

Parameters:
NUM_CH, 4, number of DMA channels (1..16)
CH_W, (NUM_CH>1 ? $clog2(NUM_CH) : 1), width of channel index

Ports:
CLK  input  1  system clock
RESET_N  input  1  asynchronous active-low reset
DREQ  input  NUM_CH  raw channel requests, polarity set by dreqActiveLow
DACK  output  NUM_CH  channel acknowledges, polarity set by dackActiveHigh
HRQ  output  1  hold request to CPU
HLDA  input  1  hold acknowledge from CPU
maskReg  input  NUM_CH  1 = channel hardware request masked
swRequest  input  NUM_CH  software request bits (ignore mask and polarity)
rotatingPriority  input  1  0 = fixed priority (ch0 highest), 1 = rotating
dreqActiveLow  input  1  command-register DREQ sense
dackActiveHigh  input  1  command-register DACK sense
controllerDisable  input  1  command-register disable bit
transferDone  input  1  end of service for the granted channel, from timing and control
grantValid  output  1  a channel is currently granted
grantChannel  output  CH_W  index of granted channel, 0 when grantValid = 0

Behaviour:
- Effective request: req[i] = ((DREQ[i] ^ dreqActiveLow) & ~maskReg[i]) | swRequest[i]. Sampled on posedge CLK.
- States (dma_pkg::arb_state_t): IDLE, REQ, GRANT, RELEASE. One-hot encoding.
- IDLE: if |req and !controllerDisable -> REQ.
  - HRQ is registered: it is 1 from the cycle after the request is seen.
- REQ: HRQ = 1. Winner is recomputed every cycle.
  - All requests withdrawn, or controllerDisable = 1 -> IDLE; HRQ drops next cycle.
  - Otherwise HLDA = 1 -> latch winner -> GRANT.
- GRANT: HRQ = 1, grantValid = 1, the latched channel's DACK is active; all other DACKs are inactive.
  - DACK is active the cycle after HLDA is sampled high.
  - The grant does not change when req changes. A dropped DREQ does not end the grant.
  - controllerDisable does not abort the current service.
- GRANT exit conditions, with priority HLDA-drop > transferDone:
  - HLDA = 0 (bus lost) -> RELEASE.
  - transferDone = 1 -> RELEASE.
- RELEASE: HRQ = 0, DACK all inactive, grantValid = 0. Always -> IDLE next cycle. This enforces one dead cycle between services.
- Priority resolution:
  - Fixed mode: lowest index wins.
  - Rotating mode: a pointer ptr (CH_W bits) marks the highest-priority channel. Search ptr, ptr+1, ... with wrap modulo NUM_CH.
  - On entry to RELEASE from a completed or aborted grant of channel k: ptr <= (k+1) mod NUM_CH, so k becomes lowest priority. Applies in rotating mode only.
  - ptr is not updated in fixed mode.
  - Switching rotatingPriority mid-service takes effect at the next resolution.
- DACK polarity:
  - Internal one-hot grant is registered.
  - Output DACK[i] = grantOH[i] ? dackActiveHigh : ~dackActiveHigh.
  - Inactive level therefore follows dackActiveHigh at all times, including during reset.
- Reset (RESET_N = 0, asynchronous):
  - State = IDLE, HRQ = 0, grantOH = 0, grantValid = 0, grantChannel = 0, ptr = 0.
  - Release is synchronous to the next CLK edge.
- Reset mid-GRANT: DACK goes inactive immediately; no RELEASE cycle.
- NUM_CH = 1: ptr is constantly 0; arbitration reduces to request/grant.
- Widths:
  - All indexing is modulo NUM_CH.
  - Non-power-of-two NUM_CH must wrap at NUM_CH-1 -> 0, not at 2^CH_W.

Decomposition:
- dma_pkg: arb_state_t enum, MAX_CH = 16 localparam, function next_ptr(k, NUM_CH).
- Sub-module dma_rr_priority_encoder (parameter NUM_CH).
  - Inputs: req, ptr, rotating.
  - Outputs: anyReq, winner index.
  - Purely combinational, instantiated once.
- The FSM, registers and polarity logic stay in dma_priority_arbiter.

Test Plan:
- Fixed priority, all polarities default (dreqActiveLow = 0, dackActiveHigh = 0):
  - Stimulus: DREQ = 4'b0110, HLDA raised 2 cycles after HRQ.
  - Required: HRQ = 1 one cycle after the request; DACK = 4'b1101 one cycle after HLDA; grantChannel = 1.
  - After transferDone: one RELEASE cycle, then channel 2 is granted.
- Rotating priority:
  - Stimulus: DREQ = 4'b1111 held, transferDone pulsed per grant.
  - Required: grant order 0, 1, 2, 3, 0; ptr wraps 3 -> 0.
- NUM_CH = 6, rotating:
  - Stimulus: grant channel 5 then complete.
  - Required: ptr = 0, not 6; next winner with req = 6'b100001 is channel 0.
- Mask/software request:
  - Stimulus: maskReg = 4'b0001, DREQ = 4'b0001.
  - Required: HRQ stays 0.
  - Then swRequest = 4'b0001 -> channel 0 is granted.
- Abort cases:
  - HLDA drops in GRANT -> RELEASE next cycle, DACK inactive, ptr advanced in rotating mode.
  - DREQ withdrawn in REQ before HLDA -> IDLE, HRQ = 0, no DACK.
- Reset mid-GRANT with dackActiveHigh = 1:
  - Required: DACK = 4'b0000 and HRQ = 0 asynchronously; state IDLE; ptr = 0 after release.

Source files
------------

// File: rtl/dma_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dma_pkg
// Purpose  : Shared types and helpers for the DMA DREQ/DACK arbiter.
//            - arb_state_t : one-hot arbiter state encoding
//            - MAX_CH      : largest supported channel count
//            - next_ptr    : rotating-priority pointer advance with wrap at
//                            the real channel count (not at 2^CH_W)
// Revision : 1.0 - initial parametrised release
// ============================================================================
package dma_pkg;

    localparam int MAX_CH = 16;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        REQ     = 4'b0010,
        GRANT   = 4'b0100,
        RELEASE = 4'b1000
    } arb_state_t;

    // Channel k just finished, so k+1 becomes highest priority. The wrap is
    // done against num_ch so that non-power-of-two configurations never
    // point at a channel that does not exist.
    function automatic int next_ptr(input int k, input int num_ch);
        if (num_ch <= 1) begin
            return 0;
        end
        return (k + 1 >= num_ch) ? 0 : k + 1;
    endfunction

endpackage : dma_pkg
`default_nettype wire

// File: rtl/dma_rr_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module   : dma_rr_priority_encoder
// Purpose  : Combinational fixed / rotating priority encoder.
//            Fixed mode    : lowest requesting index wins.
//            Rotating mode : search starts at ptr and wraps modulo NUM_CH.
// Ports    : req      [NUM_CH] effective requests
//            ptr      [CH_W]   highest-priority channel in rotating mode
//            rotating          1 = rotating, 0 = fixed
//            any_req           at least one request present
//            winner   [CH_W]   index of the winning channel (0 if none)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module dma_rr_priority_encoder
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              rotating,
    output logic              any_req,
    output logic [CH_W-1:0]   winner
);

    int   w_start;
    logic w_found;

    // Two passes over constant indices: first the channels at or above the
    // start point, then from 0 upward. The second pass only matters when
    // nothing at or above the start point was requesting, which gives the
    // wrap-around order start, start+1, ..., NUM_CH-1, 0, ..., start-1.
    always_comb begin
        any_req = |req;
        winner  = '0;
        w_found = 1'b0;
        w_start = rotating ? int'(ptr) : 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && (i >= w_start) && req[i]) begin
                w_found = 1'b1;
                winner  = CH_W'(i);
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && req[i]) begin
                w_found = 1'b1;
                winner  = CH_W'(i);
            end
        end
    end

endmodule : dma_rr_priority_encoder
`default_nettype wire

// File: rtl/dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dma_priority_arbiter
// Purpose  : DREQ/DACK arbiter and HRQ/HLDA bus-hold handshake for an
//            NUM_CH-channel DMA controller. Resolves fixed or rotating
//            priority, requests the bus, then holds one DACK until end of
//            service, followed by one dead cycle.
// Ports    : CLK, RESET_N           clock, asynchronous active-low reset
//            DREQ      [NUM_CH]     raw requests (sense = dreqActiveLow)
//            DACK      [NUM_CH]     acknowledges (sense = dackActiveHigh)
//            HRQ / HLDA             hold request / hold acknowledge
//            maskReg   [NUM_CH]     1 = hardware request masked
//            swRequest [NUM_CH]     software requests (bypass mask/sense)
//            rotatingPriority       0 = fixed, 1 = rotating
//            dreqActiveLow          DREQ sense
//            dackActiveHigh         DACK sense
//            controllerDisable      blocks new arbitration only
//            transferDone           end of service for granted channel
//            grantValid             a channel is granted
//            grantChannel [CH_W]    granted index, 0 when not granted
// Revision : 1.0 - initial parametrised release
// ============================================================================
module dma_priority_arbiter
    import dma_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [NUM_CH-1:0] DREQ,
    output logic [NUM_CH-1:0] DACK,
    output logic              HRQ,
    input  logic              HLDA,
    input  logic [NUM_CH-1:0] maskReg,
    input  logic [NUM_CH-1:0] swRequest,
    input  logic              rotatingPriority,
    input  logic              dreqActiveLow,
    input  logic              dackActiveHigh,
    input  logic              controllerDisable,
    input  logic              transferDone,
    output logic              grantValid,
    output logic [CH_W-1:0]   grantChannel
);

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              r_hrq;
    logic [NUM_CH-1:0] r_grant_oh;
    logic [CH_W-1:0]   r_grant_ch;
    logic [CH_W-1:0]   r_ptr;

    logic [NUM_CH-1:0] w_req;
    logic              w_any_req;
    logic [CH_W-1:0]   w_winner;
    logic [NUM_CH-1:0] w_winner_oh;
    logic              w_latch;
    logic              w_advance;

    // Hardware requests are sense-corrected and masked; software requests
    // always get through.
    assign w_req = ((DREQ ^ {NUM_CH{dreqActiveLow}}) & ~maskReg) | swRequest;

    dma_rr_priority_encoder #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_encoder (
        .req      (w_req),
        .ptr      (r_ptr),
        .rotating (rotatingPriority),
        .any_req  (w_any_req),
        .winner   (w_winner)
    );

    always_comb begin
        w_winner_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_winner_oh[i] = (w_winner == CH_W'(i));
        end
    end

    // Next-state logic. Once granted, only the bus handshake and end of
    // service matter: request changes and controllerDisable are ignored so
    // an in-flight service is never cut short by them.
    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_req && !controllerDisable) begin
                    w_state_nxt = REQ;
                end
            end
            REQ: begin
                if (!w_any_req || controllerDisable) begin
                    w_state_nxt = IDLE;
                end else if (HLDA) begin
                    w_state_nxt = GRANT;
                    w_latch     = 1'b1;
                end
            end
            GRANT: begin
                // Losing HLDA and transferDone both end the service the
                // same way; the pointer moves on either.
                if (!HLDA || transferDone) begin
                    w_state_nxt = RELEASE;
                    w_advance   = rotatingPriority;
                end
            end
            RELEASE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= IDLE;
            r_hrq      <= 1'b0;
            r_grant_oh <= '0;
            r_grant_ch <= '0;
            r_ptr      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hrq   <= (w_state_nxt == REQ) || (w_state_nxt == GRANT);
            if (w_latch) begin
                r_grant_oh <= w_winner_oh;
                r_grant_ch <= w_winner;
            end else if (w_state_nxt != GRANT) begin
                r_grant_oh <= '0;
                r_grant_ch <= '0;
            end
            if (w_advance) begin
                r_ptr <= CH_W'(next_ptr(int'(r_grant_ch), NUM_CH));
            end
        end
    end

    assign HRQ          = r_hrq;
    assign grantValid   = (r_state == GRANT);
    assign grantChannel = r_grant_ch;
    // Inactive level tracks dackActiveHigh at all times, including reset.
    assign DACK         = dackActiveHigh ? r_grant_oh : ~r_grant_oh;

endmodule : dma_priority_arbiter
`default_nettype wire

// File: tb/tb_dma_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dma_priority_arbiter
// Purpose  : Self-checking bench for dma_priority_arbiter (4- and 6-channel).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dma_priority_arbiter;

    logic       CLK;
    logic       RESET_N;
    logic [3:0] DREQ, DACK, maskReg, swRequest;
    logic       HRQ, HLDA, rotatingPriority, dreqActiveLow, dackActiveHigh;
    logic       controllerDisable, transferDone, grantValid;
    logic [1:0] grantChannel;

    logic [5:0] d6_dreq, d6_dack;
    logic       d6_hrq, d6_hlda, d6_done, d6_gv;
    logic [2:0] d6_gch;

    int n_cmp = 0;
    int n_err = 0;

    dma_priority_arbiter #(.NUM_CH(4)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DACK(DACK), .HRQ(HRQ),
        .HLDA(HLDA), .maskReg(maskReg), .swRequest(swRequest),
        .rotatingPriority(rotatingPriority), .dreqActiveLow(dreqActiveLow),
        .dackActiveHigh(dackActiveHigh), .controllerDisable(controllerDisable),
        .transferDone(transferDone), .grantValid(grantValid),
        .grantChannel(grantChannel)
    );

    dma_priority_arbiter #(.NUM_CH(6)) u_dut6 (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(d6_dreq), .DACK(d6_dack),
        .HRQ(d6_hrq), .HLDA(d6_hlda), .maskReg(6'b0), .swRequest(6'b0),
        .rotatingPriority(1'b1), .dreqActiveLow(1'b0), .dackActiveHigh(1'b0),
        .controllerDisable(1'b0), .transferDone(d6_done), .grantValid(d6_gv),
        .grantChannel(d6_gch)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    function automatic logic [3:0] exp_dack(input int ch, input logic ah);
        logic [3:0] oh;
        oh = (ch < 0) ? 4'b0000 : (4'b0001 << ch);
        return ah ? oh : ~oh;
    endfunction

    // One complete service with requests already applied: wait for HRQ,
    // grant, then end either by transferDone or by dropping HLDA.
    task automatic serve4(input int exp_ch, input bit abort, input string name);
        int cnt;
        for (cnt = 0; cnt < 10 && !HRQ; cnt++) tick();
        chk({name, "_hrq"}, HRQ, 1);
        HLDA = 1'b1;
        tick();
        chk({name, "_grant"}, {grantValid, 2'b0, grantChannel, DACK},
            {1'b1, 2'b0, 2'(exp_ch), exp_dack(exp_ch, dackActiveHigh)});
        if (abort) HLDA = 1'b0;
        else       transferDone = 1'b1;
        tick();
        transferDone = 1'b0;
        chk({name, "_release"}, {grantValid, HRQ, grantChannel, DACK},
            {1'b0, 1'b0, 2'b00, exp_dack(-1, dackActiveHigh)});
        HLDA = 1'b0;
        tick();
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit m_hrq, m_dead;
    int m_gch, m_ptr;

    function automatic int pick(input logic [3:0] req, input int start);
        for (int o = 0; o < 4; o++) begin
            if (req[(start + o) % 4]) return (start + o) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] eff_req();
        logic [3:0] r;
        for (int i = 0; i < 4; i++)
            r[i] = ((DREQ[i] ^ dreqActiveLow) & ~maskReg[i]) | swRequest[i];
        return r;
    endfunction

    task automatic model_step();
        logic [3:0] r;
        r = eff_req();
        if (m_gch >= 0) begin
            if (!HLDA || transferDone) begin
                if (rotatingPriority) m_ptr = (m_gch + 1) % 4;
                m_gch = -1; m_hrq = 0; m_dead = 1;
            end
        end else if (m_dead) begin
            m_dead = 0;
        end else if (m_hrq) begin
            if (r == 0 || controllerDisable) m_hrq = 0;
            else if (HLDA) m_gch = pick(r, rotatingPriority ? m_ptr : 0);
        end else if (r != 0 && !controllerDisable) begin
            m_hrq = 1;
        end
    endtask

    typedef struct {
        logic [3:0] dreq; logic hlda; logic done;
        logic hrq; logic [3:0] dack; logic gv; logic [1:0] gch;
    } vec_t;
    vec_t vecs[10];

    initial begin
        int cnt;
        vecs[0] = '{4'b0110, 0, 0, 1, 4'b1111, 0, 0};
        vecs[1] = '{4'b0110, 0, 0, 1, 4'b1111, 0, 0};
        vecs[2] = '{4'b0110, 1, 0, 1, 4'b1101, 1, 1};
        vecs[3] = '{4'b0110, 1, 0, 1, 4'b1101, 1, 1};
        vecs[4] = '{4'b0100, 1, 1, 0, 4'b1111, 0, 0};
        vecs[5] = '{4'b0100, 0, 0, 0, 4'b1111, 0, 0};
        vecs[6] = '{4'b0100, 0, 0, 1, 4'b1111, 0, 0};
        vecs[7] = '{4'b0100, 1, 0, 1, 4'b1011, 1, 2};
        vecs[8] = '{4'b0000, 1, 1, 0, 4'b1111, 0, 0};
        vecs[9] = '{4'b0000, 0, 0, 0, 4'b1111, 0, 0};

        RESET_N = 1'b0; DREQ = '0; HLDA = 0; maskReg = '0; swRequest = '0;
        rotatingPriority = 0; dreqActiveLow = 0; dackActiveHigh = 0;
        controllerDisable = 0; transferDone = 0;
        d6_dreq = '0; d6_hlda = 0; d6_done = 0;
        tick(); tick();
        chk("reset_state", {HRQ, grantValid, grantChannel, DACK}, {1'b0, 1'b0, 2'b00, 4'b1111});
        RESET_N = 1'b1;
        tick();

        // Fixed priority handshake table
        for (int i = 0; i < 10; i++) begin
            DREQ = vecs[i].dreq; HLDA = vecs[i].hlda; transferDone = vecs[i].done;
            tick();
            chk($sformatf("vec%0d", i), {HRQ, DACK, grantValid, grantChannel},
                {vecs[i].hrq, vecs[i].dack, vecs[i].gv, vecs[i].gch});
        end
        transferDone = 0; HLDA = 0;

        // Masked hardware request is ignored; software request bypasses mask
        maskReg = 4'b0001; DREQ = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("masked_hrq", HRQ, 0);
        end
        swRequest = 4'b0001;
        serve4(0, 0, "swreq");
        swRequest = '0; maskReg = '0; DREQ = '0;
        tick();

        // Request withdrawn while waiting for HLDA
        DREQ = 4'b0001;
        tick();
        chk("withdraw_req", HRQ, 1);
        DREQ = 4'b0000;
        tick();
        chk("withdraw_idle", {HRQ, grantValid, DACK}, {1'b0, 1'b0, 4'b1111});
        tick();
        chk("withdraw_stay", {HRQ, grantValid, DACK}, {1'b0, 1'b0, 4'b1111});

        // Rotating priority, all channels requesting
        rotatingPriority = 1; DREQ = 4'b1111;
        serve4(0, 0, "rot0");
        serve4(1, 0, "rot1");
        serve4(2, 0, "rot2");
        serve4(3, 0, "rot3");
        serve4(0, 0, "rot_wrap");

        // HLDA lost mid-grant: release, pointer still advances
        serve4(1, 1, "abort1");
        serve4(2, 0, "after_abort");

        // Reset during a grant with active-high DACK
        dackActiveHigh = 1;
        for (cnt = 0; cnt < 10 && !HRQ; cnt++) tick();
        HLDA = 1;
        tick();
        chk("pre_reset_grant", {grantChannel, DACK}, {2'd3, 4'b1000});
        #2 RESET_N = 1'b0;
        #1 chk("async_reset", {HRQ, grantValid, grantChannel, DACK}, {1'b0, 1'b0, 2'b00, 4'b0000});
        HLDA = 0;
        tick();
        RESET_N = 1'b1;
        serve4(0, 0, "post_reset_ptr0");
        dackActiveHigh = 0; DREQ = '0; rotatingPriority = 0;

        // Six channels: pointer must wrap 5 -> 0
        d6_dreq = 6'b100000;
        for (cnt = 0; cnt < 10 && !d6_hrq; cnt++) tick();
        d6_hlda = 1;
        tick();
        chk("ch6_grant5", {d6_gv, d6_gch, d6_dack}, {1'b1, 3'd5, 6'b011111});
        d6_done = 1;
        tick();
        d6_done = 0; d6_hlda = 0;
        chk("ch6_ptr_wrap", u_dut6.r_ptr, 0);
        d6_dreq = 6'b100001;
        for (cnt = 0; cnt < 10 && !d6_hrq; cnt++) tick();
        d6_hlda = 1;
        tick();
        chk("ch6_grant0", {d6_gv, d6_gch, d6_dack}, {1'b1, 3'd0, 6'b111110});
        d6_hlda = 0; d6_dreq = '0;
        tick();

        // Randomized run against the reference model
        RESET_N = 1'b0;
        tick();
        RESET_N = 1'b1;
        m_hrq = 0; m_dead = 0; m_gch = -1; m_ptr = 0;
        for (int i = 0; i < 3000; i++) begin
            DREQ = 4'($urandom);
            maskReg = ($urandom % 4 == 0) ? 4'($urandom) : 4'b0;
            swRequest = ($urandom % 8 == 0) ? 4'($urandom) : 4'b0;
            HLDA = ($urandom % 4 != 0) ? m_hrq : 1'($urandom);
            transferDone = ($urandom % 4 == 0);
            controllerDisable = ($urandom % 16 == 0);
            if (i % 200 == 0) rotatingPriority = 1'($urandom);
            if (i % 300 == 0) dreqActiveLow = 1'($urandom);
            if (i % 250 == 0) dackActiveHigh = 1'($urandom);
            @(posedge CLK);
            model_step();
            @(negedge CLK);
            chk($sformatf("rand%0d", i), {HRQ, grantValid, 2'b0, grantChannel, DACK},
                {m_hrq, (m_gch >= 0), 2'b0, 2'((m_gch >= 0) ? m_gch : 0),
                 exp_dack(m_gch, dackActiveHigh)});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_dma_priority_arbiter
`default_nettype wire
